// File: rtl/dwt_pkg.sv
// rtl/dwt_pkg.sv - shared constants and scheduler state type for the DWT line scheduler
package dwt_pkg;

    // Sample width from data_gen and default line geometry.
    localparam int DW_DEF       = 9;
    localparam int LINE_LEN_DEF = 64;
    localparam int LINES_DEF    = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } sched_state_t;

endpackage

// File: rtl/dwt_line_writer.sv
// rtl/dwt_line_writer.sv - packs the sample stream into the ping-pong line buffer
//
// Purpose: owns wr_ptr, wr_bank and the sticky overflow flag; drives the
// registered buffer write port. A sample is accepted only when the bank it
// would land in is not full; otherwise it is dropped and flagged.
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   i_valid, i_data    sample strobe and data from data_gen
//   i_bank_full[1:0]   per-bank full flags held by the scheduler
//   o_bank_set         pulse: the last sample of a line is accepted this cycle
//   o_set_bank         bank that o_bank_set refers to
//   o_we/o_wbank/o_waddr/o_wdata   registered line-buffer write port
//   o_overflow         sticky overrun flag
module dwt_line_writer
    import dwt_pkg::*;
#(
    parameter  int DW       = DW_DEF,
    parameter  int LINE_LEN = LINE_LEN_DEF,
    localparam int AW       = $clog2(LINE_LEN)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_valid,
    input  logic [DW-1:0] i_data,
    input  logic [1:0]    i_bank_full,
    output logic          o_bank_set,
    output logic          o_set_bank,
    output logic          o_we,
    output logic          o_wbank,
    output logic [AW-1:0] o_waddr,
    output logic [DW-1:0] o_wdata,
    output logic          o_overflow
);

    logic [AW-1:0] r_wr_ptr;
    logic          r_wr_bank;
    logic          r_we;
    logic          r_wbank;
    logic [AW-1:0] r_waddr;
    logic [DW-1:0] r_wdata;
    logic          r_overflow;

    logic w_full;
    logic w_accept;
    logic w_last;

    assign w_full   = i_bank_full[r_wr_bank];
    assign w_accept = i_valid && !w_full;
    assign w_last   = (r_wr_ptr == AW'(LINE_LEN - 1));

    // Combinational so the scheduler marks the bank full on the same edge
    // that the final sample is accepted.
    assign o_bank_set = w_accept && w_last;
    assign o_set_bank = r_wr_bank;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr   <= '0;
            r_wr_bank  <= 1'b0;
            r_we       <= 1'b0;
            r_wbank    <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_we <= w_accept;
            if (w_accept) begin
                r_wbank  <= r_wr_bank;
                r_waddr  <= r_wr_ptr;
                r_wdata  <= i_data;
                // LINE_LEN is a power of two, so the pointer wraps by itself.
                r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_last) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end
            if (i_valid && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_we       = r_we;
    assign o_wbank    = r_wbank;
    assign o_waddr    = r_waddr;
    assign o_wdata    = r_wdata;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/dwt_line_sched.sv
// rtl/dwt_line_sched.sv - ping-pong line scheduler between data_gen and the DWT core
//
// Purpose: fills two line-buffer banks from the sample stream and hands each
// full bank to the DWT core with a start/done handshake; tracks line index,
// frame completion and overruns.
// Ports:
//   clk, rstn                          clock, asynchronous active-low reset
//   in_valid, in_data                  sample stream (no backpressure)
//   buf_we/buf_wbank/buf_waddr/buf_wdata   line-buffer write port
//   dwt_start, dwt_bank, dwt_done      core handshake
//   line_idx                           line owned by / next handed to the core
//   frame_done                         pulse with the done of the last line
//   busy                               scheduler not idle
//   overflow                           sticky overrun flag
module dwt_line_sched
    import dwt_pkg::*;
#(
    parameter  int DW       = DW_DEF,
    parameter  int LINE_LEN = LINE_LEN_DEF,
    parameter  int LINES    = LINES_DEF,
    localparam int AW       = $clog2(LINE_LEN),
    localparam int LW       = $clog2(LINES)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          buf_we,
    output logic          buf_wbank,
    output logic [AW-1:0] buf_waddr,
    output logic [DW-1:0] buf_wdata,
    output logic          dwt_start,
    output logic          dwt_bank,
    input  logic          dwt_done,
    output logic [LW-1:0] line_idx,
    output logic          frame_done,
    output logic          busy,
    output logic          overflow
);

    sched_state_t  r_state;
    sched_state_t  w_state_nxt;
    logic [1:0]    r_bank_full;
    logic [1:0]    w_bank_full_nxt;
    logic          r_rd_bank;
    logic [LW-1:0] r_line_idx;

    logic w_bank_set;
    logic w_set_bank;
    logic w_release;
    logic w_last_line;

    dwt_line_writer #(
        .DW       (DW),
        .LINE_LEN (LINE_LEN)
    ) u_writer (
        .clk         (clk),
        .rstn        (rstn),
        .i_valid     (in_valid),
        .i_data      (in_data),
        .i_bank_full (r_bank_full),
        .o_bank_set  (w_bank_set),
        .o_set_bank  (w_set_bank),
        .o_we        (buf_we),
        .o_wbank     (buf_wbank),
        .o_waddr     (buf_waddr),
        .o_wdata     (buf_wdata),
        .o_overflow  (overflow)
    );

    assign w_release   = (r_state == WAIT) && dwt_done;
    assign w_last_line = (r_line_idx == LW'(LINES - 1));

    // The writer never targets a full bank, so a set and a release in the
    // same cycle always hit different bits and both are applied.
    always_comb begin
        w_bank_full_nxt = r_bank_full;
        if (w_bank_set) begin
            w_bank_full_nxt[w_set_bank] = 1'b1;
        end
        if (w_release) begin
            w_bank_full_nxt[r_rd_bank] = 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        dwt_start   = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_bank_full[r_rd_bank]) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                dwt_start   = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (dwt_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_bank_full <= 2'b00;
            r_rd_bank   <= 1'b0;
            r_line_idx  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_bank_full <= w_bank_full_nxt;
            if (w_release) begin
                r_rd_bank  <= ~r_rd_bank;
                r_line_idx <= w_last_line ? '0 : r_line_idx + LW'(1);
            end
        end
    end

    assign dwt_bank   = r_rd_bank;
    assign line_idx   = r_line_idx;
    assign frame_done = w_release && w_last_line;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_dwt_line_sched.sv
// tb/tb_dwt_line_sched.sv - scoreboard bench for dwt_line_sched
module tb_dwt_line_sched;

    localparam int DW = 9;
    localparam int AW = 6;
    localparam int LW = 6;

    logic          clk = 1'b0;
    logic          rstn;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          buf_we;
    logic          buf_wbank;
    logic [AW-1:0] buf_waddr;
    logic [DW-1:0] buf_wdata;
    logic          dwt_start;
    logic          dwt_bank;
    logic          dwt_done;
    logic [LW-1:0] line_idx;
    logic          frame_done;
    logic          busy;
    logic          overflow;

    dwt_line_sched dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .buf_we     (buf_we),
        .buf_wbank  (buf_wbank),
        .buf_waddr  (buf_waddr),
        .buf_wdata  (buf_wdata),
        .dwt_start  (dwt_start),
        .dwt_bank   (dwt_bank),
        .dwt_done   (dwt_done),
        .line_idx   (line_idx),
        .frame_done (frame_done),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic          b;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            c;
    } wr_t;

    typedef struct {
        logic          b;
        logic [LW-1:0] l;
        int            c;
    } st_t;

    wr_t wq[$];
    st_t sq[$];
    int  fq[$];

    int n_checks = 0;
    int n_pass   = 0;

    logic          exp_wbank;
    logic [AW-1:0] exp_waddr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    wr_t e_wr;
    st_t e_st;
    int  e_fd;
    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            if (buf_we) begin
                if (wq.size() == 0) chk("unexpected_buf_we", 32'd1, 32'd0);
                else begin
                    e_wr = wq.pop_front();
                    chk("wr_bank", 32'(buf_wbank), 32'(e_wr.b));
                    chk("wr_addr", 32'(buf_waddr), 32'(e_wr.a));
                    chk("wr_data", 32'(buf_wdata), 32'(e_wr.d));
                    chk("wr_cycle", cyc, e_wr.c);
                end
            end
            if (dwt_start) begin
                if (sq.size() == 0) chk("unexpected_dwt_start", 32'd1, 32'd0);
                else begin
                    e_st = sq.pop_front();
                    chk("start_bank", 32'(dwt_bank), 32'(e_st.b));
                    chk("start_line_idx", 32'(line_idx), 32'(e_st.l));
                    chk("start_cycle", cyc, e_st.c);
                end
            end
            if (frame_done) begin
                if (fq.size() == 0) chk("unexpected_frame_done", 32'd1, 32'd0);
                else begin
                    e_fd = fq.pop_front();
                    chk("frame_done_cycle", cyc, e_fd);
                end
            end
        end
    end

    // One cycle of stimulus; acc says whether the sample must be written.
    task automatic step(input bit v, input logic [DW-1:0] d, input bit acc, input bit done);
        in_valid = v;
        in_data  = d;
        dwt_done = done;
        if (v && acc) begin
            wq.push_back('{b: exp_wbank, a: exp_waddr, d: d, c: cyc + 1});
            exp_waddr = exp_waddr + 1'b1;
            if (exp_waddr == '0) exp_wbank = ~exp_wbank;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dwt_done = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_buf_we"}, 32'(buf_we), 32'd0);
        chk({tag, "_buf_wbank"}, 32'(buf_wbank), 32'd0);
        chk({tag, "_buf_waddr"}, 32'(buf_waddr), 32'd0);
        chk({tag, "_buf_wdata"}, 32'(buf_wdata), 32'd0);
        chk({tag, "_dwt_start"}, 32'(dwt_start), 32'd0);
        chk({tag, "_dwt_bank"}, 32'(dwt_bank), 32'd0);
        chk({tag, "_line_idx"}, 32'(line_idx), 32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    task automatic apply_reset(input string tag);
        rstn = 1'b0;
        #1;
        chk_reset_outputs(tag);
        chk({tag, "_wq_drained"}, 32'(wq.size()), 32'd0);
        chk({tag, "_sq_drained"}, 32'(sq.size()), 32'd0);
        exp_wbank = 1'b0;
        exp_waddr = '0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    int d0;

    initial begin
        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        dwt_done  = 1'b0;
        exp_wbank = 1'b0;
        exp_waddr = '0;

        // Reset state, then idle: nothing may start.
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        rstn = 1'b1;
        repeat (10) step(1'b0, '0, 1'b0, 1'b0);
        chk("idle_busy", 32'(busy), 32'd0);

        // Line 0: samples 0..63 into bank0, start 2 cycles after last sample.
        for (int i = 0; i < 64; i++) begin
            if (i == 63) sq.push_back('{b: 1'b0, l: 6'd0, c: cyc + 2});
            step(1'b1, DW'(i), 1'b1, 1'b0);
        end
        // Line 1 fills bank1 while the core holds bank0.
        for (int i = 64; i < 128; i++) step(1'b1, DW'(i), 1'b1, 1'b0);
        chk("wait_busy", 32'(busy), 32'd1);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        // Back-to-back: bank1 already full, start 2 cycles after done.
        d0 = cyc;
        sq.push_back('{b: 1'b1, l: 6'd1, c: d0 + 2});
        step(1'b0, '0, 1'b0, 1'b1);
        chk("line_idx_after_done", 32'(line_idx), 32'd1);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("line_idx_2", 32'(line_idx), 32'd2);

        // Overrun: core stalled, 130 samples -> 128 written, 2 dropped;
        // the second drop coincides with dwt_done and still counts.
        chk("overflow_clear", 32'(overflow), 32'd0);
        for (int i = 0; i < 128; i++) begin
            if (i == 63) sq.push_back('{b: 1'b0, l: 6'd2, c: cyc + 2});
            step(1'b1, DW'(300 + i), 1'b1, 1'b0);
        end
        step(1'b1, 9'h1aa, 1'b0, 1'b0);
        d0 = cyc;
        sq.push_back('{b: 1'b1, l: 6'd3, c: d0 + 2});
        step(1'b1, 9'h155, 1'b0, 1'b1);
        chk("overflow_set", 32'(overflow), 32'd1);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("overflow_sticky", 32'(overflow), 32'd1);
        chk("line_idx_4", 32'(line_idx), 32'd4);

        // Reset mid-line (wr_ptr=30), then a full line lands at bank0 addr 0.
        for (int i = 0; i < 30; i++) step(1'b1, DW'(i + 7), 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        apply_reset("rst_midline");
        for (int i = 0; i < 64; i++) begin
            if (i == 63) sq.push_back('{b: 1'b0, l: 6'd0, c: cyc + 2});
            step(1'b1, DW'(200 + i), 1'b1, 1'b0);
        end
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("busy_in_wait", 32'(busy), 32'd1);
        apply_reset("rst_wait");

        // Full frame of 64 lines: one frame_done, with the 64th dwt_done.
        for (int ln = 0; ln < 64; ln++) begin
            for (int i = 0; i < 64; i++) begin
                if (i == 63) sq.push_back('{b: 1'(ln % 2), l: 6'(ln), c: cyc + 2});
                step(1'b1, DW'(ln * 3 + i), 1'b1, 1'b0);
            end
            step(1'b0, '0, 1'b0, 1'b0);
            step(1'b0, '0, 1'b0, 1'b0);
            if (ln == 63) fq.push_back(cyc);
            step(1'b0, '0, 1'b0, 1'b1);
        end
        chk("frame_line_idx_wrap", 32'(line_idx), 32'd0);
        chk("frame_end_busy", 32'(busy), 32'd0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);

        chk("wq_empty", 32'(wq.size()), 32'd0);
        chk("sq_empty", 32'(sq.size()), 32'd0);
        chk("fq_empty", 32'(fq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
